uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receive side of the UART link; consumes the serial line driven by the transmitter stage.
- Synchronizes the async `rx` line and detects the start-bit falling edge using 16x oversample ticks.
- Samples each bit at mid-bit, checks the stop bit, and presents a parallel byte with a valid/read handshake.
- Reports framing errors and overruns to the host-side register block.

Parameters:
- OVERSAMPLE, 16, `en_os` ticks per bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; LSB first, no parity, 1 stop bit.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- en_os  input  1  oversample tick; 1-clk pulse at OVERSAMPLE x baud from the shared baud generator
- rx  input  1  asynchronous serial line; idles high
- rd_en  input  1  consumer read strobe; clears `rx_valid`
- rx_data  output  DATA_BITS  last good received byte
- rx_valid  output  1  `rx_data` holds an unread byte
- frame_err  output  1  1-clk pulse: stop bit sampled 0
- overrun  output  1  1-clk pulse: good byte completed while `rx_valid` was already set
- busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset:
  - `rst` is synchronous and active-high; clock is `clk`.
  - State goes to IDLE; tick counter and bit index clear to 0; shift reg clears to 0.
  - Sync flops reset to 1.
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - Reset mid-frame abandons the frame with no pulses.
- Synchronizer: 2 flops on `rx` produce `rx_s`; input-to-`rx_s` latency is 2 clk. All FSM decisions use `rx_s`.
- Counters advance only on cycles with `en_os`=1; without `en_os` all state holds.
  - Tick counter width is clog2(OVERSAMPLE).
  - Bit index width is clog2(DATA_BITS+1).
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: on `en_os` with `rx_s`=0, go to START with cnt=0.
  - START: cnt increments each tick. At cnt==OVERSAMPLE/2-1 (mid start bit):
    - `rx_s`=0: go to DATA, cnt=0, idx=0.
    - `rx_s`=1: false start (glitch); go to IDLE with no pulses.
  - DATA: cnt increments each tick. At cnt==OVERSAMPLE-1 (mid data bit):
    - Shift right, inserting `rx_s` at the MSB, so the first bit lands in the LSB.
    - cnt=0, idx+1.
    - After the DATA_BITS-th sample, go to STOP with cnt=0.
  - STOP: at cnt==OVERSAMPLE-1, sample the stop bit.
    - `rx_s`=1 (good frame): next clk `rx_data`=shift reg and `rx_valid`=1. If `rx_valid` was 1 and `rd_en`=0 that cycle, also pulse `overrun`; new data overwrites. Go to IDLE.
    - `rx_s`=0 (framing error/break): pulse `frame_err`; `rx_data` and `rx_valid` unchanged. Remain in STOP (break wait) until an `en_os` tick sees `rx_s`=1, then go to IDLE. This prevents a break being taken as a start bit.
- Return to IDLE happens at mid stop bit, giving half a bit of resync margin for back-to-back frames.
- `rd_en`:
  - `rx_valid` clears on the next clk.
  - `rd_en` with `rx_valid`=0 is ignored.
  - `rd_en` in the same cycle as a good-frame load: load wins, `rx_valid` stays 1, no `overrun`.
- `busy` is combinational: 1 whenever state != IDLE, including break wait.
- Sample-point latency: first data bit sampled 1.5 bit periods after the falling edge seen on `rx_s`, within ±1 `en_os` tick.

Decomposition:
- Shared package uart_pkg, reused by the transmitter:
  - State enum uart_state_e {IDLE, START, DATA, STOP} (2-bit).
  - Localparams UART_OVERSAMPLE=16, UART_DATA_BITS=8.
- One sub-module, uart_rx_sync: 2-flop synchronizer, reset value 1, parameterized width. Reused for other async inputs such as CTS.
- Bit sampler and FSM stay inline in uart_rx.

Test Plan:
- Single frame 0xA5 (line: start 0, bits 1,0,1,0,0,1,0,1, stop 1), `en_os` every 4 clk -> `rx_data`=0xA5, `rx_valid`=1 one clk after the stop mid-sample; `frame_err`=0, `overrun`=0; `busy` 1 during frame, 0 after.
- Glitch: `rx` low for 5 `en_os` ticks, then high -> FSM returns to IDLE at the 8th tick; `rx_valid` stays 0; no pulses.
- Framing error: frame 0x3C with stop bit 0, line held low for 2 further bit times -> one `frame_err` pulse; `rx_valid` unchanged; `busy` stays 1 until `rx` returns high; the next frame 0x55 is received correctly.
- Overrun and handshake:
  - Receive 0x11, no `rd_en`, then 0x22 -> `overrun` pulses once; `rx_data`=0x22; `rx_valid`=1.
  - `rd_en` then clears `rx_valid`.
  - `rd_en` coincident with the load of 0x33 -> no `overrun`; `rx_valid` stays 1.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap -> three good bytes in order (consumer reads each), no errors.
- Reset mid-frame: assert `rst` during bit 3 of 0x96 -> all outputs 0 next clk; the following full frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default frame parameters.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for asynchronous inputs, resets to 1.
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with mid-bit sampling, framing/overrun flags and read handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_os,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    uart_state_e          state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 rx_s, load, ferr;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // In STOP, idx==0 marks the break wait after a framing error
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        load    = 1'b0;
        ferr    = 1'b0;
        if (en_os) begin
            case (state)
                IDLE: begin
                    state_n = rx_s ? IDLE : START;
                    cnt_n   = '0;
                end
                START: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == MID_TICK) begin
                        state_n = rx_s ? IDLE : DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end
                end
                DATA: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == LAST_TICK) begin
                        sh_n    = {rx_s, sh[DATA_BITS-1:1]};
                        cnt_n   = '0;
                        idx_n   = idx + IW'(1);
                        state_n = (idx == LAST_BIT) ? STOP : DATA;
                    end
                end
                STOP: begin
                    if (idx == '0) begin
                        state_n = rx_s ? IDLE : STOP;
                    end else if (cnt == LAST_TICK) begin
                        load    = rx_s;
                        ferr    = !rx_s;
                        state_n = rx_s ? IDLE : STOP;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            rx_data   <= load ? sh : rx_data;
            rx_valid  <= load | (rx_valid & ~rd_en);
            frame_err <= ferr;
            overrun   <= load & rx_valid & ~rd_en;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table, directed corner sequences and random frames against a frame-level model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_os = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int div = 0;
    bit auto_rd = 1'b0;
    logic [7:0] got[$];

    typedef struct {
        logic       rd_before;
        logic [7:0] d;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         d_fe;
        int         d_ov;
    } vec_t;

    vec_t tbl[6];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .en_os     (en_os),
        .rx        (rx),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Baud generator model: en_os high one clk in every four
    initial forever begin
        @(negedge clk);
        div   = (div + 1) % 4;
        en_os = (div == 0);
    end

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (auto_rd) begin
            if (rx_valid && !rd_en) begin
                got.push_back(rx_data);
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!en_os);
        end
        #1;
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        ticks(n);
    endtask

    task automatic read();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    // Drives a full frame; rd_load pulses rd_en on the tick that samples the stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit rd_load);
        line(1'b0, 16);
        for (int b = 0; b < 8; b++) line(d[b], 16);
        if (rd_load) begin
            line(stop, 8);
            do begin
                @(negedge clk);
                #1;
            end while (!en_os);
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            ticks(7);
        end else begin
            line(stop, 16);
        end
    endtask

    initial begin
        int fe0, ov0, nbad;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        bit good;
        tbl[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 0, 0};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1, 0};
        tbl[2] = '{1'b0, 8'h55, 1'b1, 1'b1, 8'h55, 0, 0};
        tbl[3] = '{1'b0, 8'h11, 1'b1, 1'b1, 8'h11, 0, 1};
        tbl[4] = '{1'b0, 8'h22, 1'b1, 1'b1, 8'h22, 0, 1};
        tbl[5] = '{1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 0, 0};
        repeat (4) @(posedge clk);
        #1;
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        line(1'b1, 16);
        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            if (tbl[i].rd_before) begin
                read();
                chk("pre-read rx_valid", rx_valid, 0);
            end
            send_frame(tbl[i].d, tbl[i].stop, 0);
            line(1'b1, 16);
            chk($sformatf("vec%0d rx_data", i), rx_data, tbl[i].exp_data);
            chk($sformatf("vec%0d rx_valid", i), rx_valid, tbl[i].exp_valid);
            chk($sformatf("vec%0d frame_err", i), fe_cnt - fe0, tbl[i].d_fe);
            chk($sformatf("vec%0d overrun", i), ov_cnt - ov0, tbl[i].d_ov);
            chk($sformatf("vec%0d busy", i), busy, 0);
        end
        read();
        chk("handshake rx_valid", rx_valid, 0);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx = 1'b0;
        ticks(3);
        chk("glitch busy mid", busy, 1);
        ticks(2);
        line(1'b1, 8);
        chk("glitch busy after", busy, 0);
        chk("glitch rx_valid", rx_valid, 0);
        chk("glitch pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        send_frame(8'h3C, 1'b0, 0);
        line(1'b0, 32);
        chk("break busy", busy, 1);
        chk("break frame_err", fe_cnt - fe0, 1);
        chk("break rx_valid", rx_valid, 0);
        chk("break rx_data", rx_data, 8'h81);
        line(1'b1, 4);
        chk("break release busy", busy, 0);
        line(1'b1, 12);
        send_frame(8'h55, 1'b1, 0);
        line(1'b1, 4);
        chk("after break rx_data", rx_data, 8'h55);
        chk("after break rx_valid", rx_valid, 1);
        send_frame(8'h33, 1'b1, 1);
        line(1'b1, 4);
        chk("coincident rd rx_data", rx_data, 8'h33);
        chk("coincident rd rx_valid", rx_valid, 1);
        chk("coincident rd overrun", ov_cnt - ov0, 0);
        line(1'b0, 16);
        for (int b = 0; b < 3; b++) line(b[0] ? 1'b1 : 1'b0, 16);
        line(1'b0, 8);
        chk("pre-reset busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid reset rx_data", rx_data, 0);
        chk("mid reset rx_valid", rx_valid, 0);
        chk("mid reset busy", busy, 0);
        rst = 1'b0;
        line(1'b1, 16);
        send_frame(8'h96, 1'b1, 0);
        line(1'b1, 4);
        chk("post reset rx_data", rx_data, 8'h96);
        chk("post reset rx_valid", rx_valid, 1);
        chk("reset frame pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 1);
        auto_rd = 1'b1;
        line(1'b1, 4);
        got.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h81, 1'b1, 0);
        line(1'b1, 16);
        chk("b2b count", got.size(), 3);
        if (got.size() == 3) begin
            chk("b2b byte0", got[0], 8'h00);
            chk("b2b byte1", got[1], 8'hFF);
            chk("b2b byte2", got[2], 8'h81);
        end
        chk("b2b errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        got.delete();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        nbad = 0;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(d, good, 0);
            if (good) begin
                exp_q.push_back(d);
            end else begin
                nbad++;
                line(1'b0, $urandom_range(0, 40));
                line(1'b1, 16);
            end
            line(1'b1, $urandom_range(0, 20));
        end
        line(1'b1, 16);
        chk("rand count", got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk($sformatf("rand byte%0d", k), got[k], exp_q[k]);
        chk("rand frame_err", fe_cnt - fe0, nbad);
        chk("rand overrun", ov_cnt - ov0, 0);
        chk("rand busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
